// File: rtl/opll_seq_pkg.sv
// Shared types and constants for the OPLL host-write sequencer.
package opll_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic       a0;
    logic [7:0] d;
  } seq_entry_t;

  // YM2413 minimum idle time after an address / data write, in master clocks
  localparam int DEF_ADDR_WAIT = 12;
  localparam int DEF_DATA_WAIT = 84;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/opll_seq_fifo.sv
// Synchronous FIFO: power-of-two depth, registered storage and pointers,
// occupancy counter. A push while full is accepted only when a pop
// frees the slot in the same cycle.
module opll_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_level == '0);
  assign o_full    = (r_level == LW'(DEPTH));
  assign o_level   = r_level;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage write; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/opll_bus_sequencer.sv
// Host-write sequencer for the OPLL core CPU port.
// Synchronises raw host strobes, queues writes and replays them with the
// YM2413 address/data wait times.
// Optional build macro: OPLL_SEQ_ADDR_CACHE_EN (skip repeated address writes).
//
// state  | meaning
// IDLE   | nothing in flight; pop the FIFO head when present
// STROBE | cs_n/wr_n held low, counter runs out the strobe width
// WAIT   | strobe released, counter runs out the chip's recovery time
module opll_bus_sequencer
  import opll_seq_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int STROBE_CYCLES = 2,
  parameter int ADDR_WAIT     = DEF_ADDR_WAIT,
  parameter int DATA_WAIT     = DEF_DATA_WAIT
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_host_wr,
  input  logic                            i_host_a0,
  input  logic [7:0]                      i_host_d,
  input  logic                            i_ovf_clr,
  output logic                            o_opll_cs_n,
  output logic                            o_opll_wr_n,
  output logic                            o_opll_a0,
  output logic [7:0]                      o_opll_d,
  output logic                            o_busy,
  output logic                            o_full,
  output logic                            o_overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_level
);

  localparam int CW = $clog2(max3(STROBE_CYCLES, ADDR_WAIT, DATA_WAIT) + 1);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] C_STROBE = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] C_ADDR   = CW'(ADDR_WAIT - 1);
  localparam logic [CW-1:0] C_DATA   = CW'(DATA_WAIT - 1);

  logic          r_sync1_wr, r_sync2_wr, r_prev_wr;
  logic          r_sync1_a0, r_sync2_a0;
  logic [7:0]    r_sync1_d,  r_sync2_d;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [LW-1:0] w_level;
  seq_entry_t    w_push_entry;
  seq_entry_t    w_head;

  seq_state_t    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_strobe_n, w_strobe_n_nxt;
  logic          r_a0, w_a0_nxt;
  logic [7:0]    r_d, w_d_nxt;
  logic          w_start;
  logic          w_skip;
  logic          w_issue;
  logic          r_overflow;
  logic          w_ovf_evt;

  // Two-flop synchroniser on all host pins plus edge-detect flop on the strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1_wr <= 1'b0;
      r_sync2_wr <= 1'b0;
      r_prev_wr  <= 1'b0;
      r_sync1_a0 <= 1'b0;
      r_sync2_a0 <= 1'b0;
      r_sync1_d  <= '0;
      r_sync2_d  <= '0;
    end else begin
      r_sync1_wr <= i_host_wr;
      r_sync2_wr <= r_sync1_wr;
      r_prev_wr  <= r_sync2_wr;
      r_sync1_a0 <= i_host_a0;
      r_sync2_a0 <= r_sync1_a0;
      r_sync1_d  <= i_host_d;
      r_sync2_d  <= r_sync1_d;
    end
  end

  assign w_push          = r_sync2_wr & ~r_prev_wr;
  assign w_push_entry.a0 = r_sync2_a0;
  assign w_push_entry.d  = r_sync2_d;

  opll_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(seq_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (w_push_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

`ifdef OPLL_SEQ_ADDR_CACHE_EN
  logic       r_cache_valid;
  logic [7:0] r_cache_addr;

  assign w_skip = ~w_head.a0 & r_cache_valid & (r_cache_addr == w_head.d);

  // Remember the last address actually issued to the core
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cache_valid <= 1'b0;
      r_cache_addr  <= '0;
    end else if (w_issue && !w_head.a0) begin
      r_cache_valid <= 1'b1;
      r_cache_addr  <= w_head.d;
    end
  end
`else
  assign w_skip = 1'b0;
`endif

  // Sequencer state, counter and core-port output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_strobe_n <= 1'b1;
      r_a0       <= 1'b0;
      r_d        <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_strobe_n <= w_strobe_n_nxt;
      r_a0       <= w_a0_nxt;
      r_d        <= w_d_nxt;
    end
  end

  // Next-state logic; a pop from IDLE or the end of WAIT shares one path
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_strobe_n_nxt = r_strobe_n;
    w_a0_nxt       = r_a0;
    w_d_nxt        = r_d;
    w_start        = 1'b0;
    w_pop          = 1'b0;
    w_issue        = 1'b0;
    case (r_state)
      IDLE: begin
        w_start = ~w_empty;
      end
      STROBE: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else begin
          w_strobe_n_nxt = 1'b1;
          w_cnt_nxt      = r_a0 ? C_DATA : C_ADDR;
          w_state_nxt    = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else begin
          w_state_nxt = IDLE;
          w_start     = ~w_empty;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_start) begin
      w_pop = 1'b1;
      if (w_skip) begin
        // cached address: drop it and look at the next entry next cycle
        w_state_nxt = IDLE;
      end else begin
        w_issue        = 1'b1;
        w_state_nxt    = STROBE;
        w_strobe_n_nxt = 1'b0;
        w_a0_nxt       = w_head.a0;
        w_d_nxt        = w_head.d;
        w_cnt_nxt      = C_STROBE;
      end
    end
  end

  assign w_ovf_evt = w_push & w_full & ~w_pop;

  // Sticky overflow; a new drop wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_overflow <= 1'b0;
    else if (w_ovf_evt)  r_overflow <= 1'b1;
    else if (i_ovf_clr)  r_overflow <= 1'b0;
  end

  assign o_opll_cs_n = r_strobe_n;
  assign o_opll_wr_n = r_strobe_n;
  assign o_opll_a0   = r_a0;
  assign o_opll_d    = r_d;
  assign o_busy      = (r_state != IDLE) | ~w_empty;
  assign o_full      = w_full;
  assign o_overflow  = r_overflow;
  assign o_level     = w_level;

endmodule

// File: tb/tb_opll_bus_sequencer.sv
// Self-checking bench for opll_bus_sequencer (default parameters).
module tb_opll_bus_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_host_wr, i_host_a0, i_ovf_clr;
  logic [7:0] i_host_d;
  logic       o_opll_cs_n, o_opll_wr_n, o_opll_a0;
  logic [7:0] o_opll_d;
  logic       o_busy, o_full, o_overflow;
  logic [2:0] o_level;

  opll_bus_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_host_wr   (i_host_wr),
    .i_host_a0   (i_host_a0),
    .i_host_d    (i_host_d),
    .i_ovf_clr   (i_ovf_clr),
    .o_opll_cs_n (o_opll_cs_n),
    .o_opll_wr_n (o_opll_wr_n),
    .o_opll_a0   (o_opll_a0),
    .o_opll_d    (o_opll_d),
    .o_busy      (o_busy),
    .o_full      (o_full),
    .o_overflow  (o_overflow),
    .o_level     (o_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: strobe edges, widths, busy windows and peak level per window
  int   fall_q[$];
  int   strobes = 0;
  int   last_width = 0;
  logic cs_at_fall = 1'b1;
  logic prev_wr_n = 1'b1;
  int   busy_run = 0;
  int   last_busy_len = 0;
  int   peak = 0;
  int   last_peak = 0;

  always @(negedge clk) begin
    if (prev_wr_n && !o_opll_wr_n) begin
      fall_q.push_back(cyc);
      cs_at_fall = o_opll_cs_n;
      strobes++;
    end
    if (!prev_wr_n && o_opll_wr_n && fall_q.size() > 0)
      last_width = cyc - fall_q[fall_q.size()-1];
    if (o_busy) begin
      busy_run++;
      if (int'(o_level) > peak) peak = int'(o_level);
    end else if (busy_run != 0) begin
      last_busy_len = busy_run;
      last_peak     = peak;
      busy_run      = 0;
      peak          = 0;
    end
    prev_wr_n = o_opll_wr_n;
  end

  int n_checks = 0;
  int n_errors = 0;
  int t_pin    = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int fall_at(input int i);
    if (i < fall_q.size()) return fall_q[i];
    return -100000;
  endfunction

  task automatic host_write(input logic a0, input logic [7:0] d, input int hi);
    @(negedge clk);
    i_host_a0 = a0;
    i_host_d  = d;
    i_host_wr = 1'b1;
    t_pin     = cyc + 1;
    repeat (hi) @(negedge clk);
    i_host_wr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (o_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(o_busy), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs_n"},  int'(o_opll_cs_n), 1);
    check({tag, "_wr_n"},  int'(o_opll_wr_n), 1);
    check({tag, "_a0"},    int'(o_opll_a0),   0);
    check({tag, "_d"},     int'(o_opll_d),    0);
    check({tag, "_busy"},  int'(o_busy),      0);
    check({tag, "_full"},  int'(o_full),      0);
    check({tag, "_ovf"},   int'(o_overflow),  0);
    check({tag, "_level"}, int'(o_level),     0);
  endtask

  typedef struct {
    logic       a0;
    logic [7:0] d;
    int         exp_lat;
    int         exp_width;
    int         exp_busy;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int s0;
    int idx;

    vecs[0] = '{1'b0, 8'h30, 3, 2, 15};
    vecs[1] = '{1'b1, 8'hA5, 3, 2, 87};
    vecs[2] = '{1'b0, 8'h00, 3, 2, 15};
    vecs[3] = '{1'b1, 8'hFF, 3, 2, 87};

    rst_n = 1'b0;
    i_host_wr = 1'b0;
    i_host_a0 = 1'b0;
    i_host_d  = 8'h00;
    i_ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single writes, one at a time from idle
    for (int i = 0; i < 4; i++) begin
      s0  = strobes;
      idx = fall_q.size();
      host_write(vecs[i].a0, vecs[i].d, 2);
      wait_idle(300, "single_idle");
      check("single_count", strobes - s0, 1);
      check("single_latency", fall_at(idx) - t_pin, vecs[i].exp_lat);
      check("single_width", last_width, vecs[i].exp_width);
      check("single_cs_low", int'(cs_at_fall), 0);
      check("single_busy_len", last_busy_len, vecs[i].exp_busy);
      check("single_a0", int'(o_opll_a0), int'(vecs[i].a0));
      check("single_d", int'(o_opll_d), int'(vecs[i].d));
    end

    // Burst: addr 0x10, data 0x55, addr 0x11
    s0  = strobes;
    idx = fall_q.size();
    host_write(1'b0, 8'h10, 2);
    host_write(1'b1, 8'h55, 2);
    host_write(1'b0, 8'h11, 2);
    wait_idle(500, "burst_idle");
    check("burst_count", strobes - s0, 3);
    check("burst_gap_addr", fall_at(idx+1) - fall_at(idx), 14);
    check("burst_gap_data", fall_at(idx+2) - fall_at(idx+1), 86);
    check("burst_peak_level", last_peak, 2);
    check("burst_last_d", int'(o_opll_d), 8'h11);

    // Overflow: six writes queued behind a data write's long wait
    s0 = strobes;
    host_write(1'b1, 8'h00, 2);
    for (int i = 0; i < 6; i++) host_write(1'b0, 8'(i), 2);
    check("ovf_full", int'(o_full), 1);
    check("ovf_level", int'(o_level), 4);
    check("ovf_flag", int'(o_overflow), 1);
    i_ovf_clr = 1'b1;
    @(negedge clk);
    i_ovf_clr = 1'b0;
    check("ovf_cleared", int'(o_overflow), 0);
    check("ovf_still_full", int'(o_full), 1);
    wait_idle(1000, "ovf_idle");
    check("ovf_count", strobes - s0, 5);
    check("ovf_last_d", int'(o_opll_d), 3);
    check("ovf_level_drained", int'(o_level), 0);

    // Held-high strobe gives exactly one write
    s0 = strobes;
    host_write(1'b1, 8'h5A, 200);
    wait_idle(300, "hold_idle");
    check("hold_count", strobes - s0, 1);
    check("hold_d", int'(o_opll_d), 8'h5A);

    // Reset mid-WAIT with two entries queued
    host_write(1'b1, 8'h77, 2);
    host_write(1'b0, 8'h01, 2);
    host_write(1'b0, 8'h02, 2);
    check("pre_rst_level", int'(o_level), 2);
    check("pre_rst_d", int'(o_opll_d), 8'h77);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    s0 = strobes;
    repeat (150) @(negedge clk);
    check("post_rst_strobes", strobes - s0, 0);
    check("post_rst_busy", int'(o_busy), 0);

    // Repeated address sequence
    s0 = strobes;
    host_write(1'b0, 8'h20, 2);
    host_write(1'b1, 8'h01, 2);
    host_write(1'b0, 8'h20, 2);
    host_write(1'b1, 8'h02, 2);
    wait_idle(600, "cache_idle");
`ifdef OPLL_SEQ_ADDR_CACHE_EN
    check("cache_count", strobes - s0, 3);
`else
    check("cache_count", strobes - s0, 4);
`endif
    check("cache_last_d", int'(o_opll_d), 8'h02);
    check("cache_last_a0", int'(o_opll_a0), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
